// File: rtl/ram_march_bist.sv
// March BIST engine for a single-port synchronous RAM: WR0 (pattern up), RD0W1 (read pattern / write inverse, up), RD1 (read inverse, down).
// Optional macro RAM_MARCH_BIST_ERRCNT_EN: count mismatches instead of aborting on the first one.
module ram_march_bist #(
    parameter int            AW      = 4,
    parameter int            DW      = 4,
    parameter logic [DW-1:0] PATTERN = 4'hA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] din,
    input  logic [DW-1:0] dout
`ifdef RAM_MARCH_BIST_ERRCNT_EN
    ,
    output logic [AW:0]   err_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR0   = 3'd1;
    localparam logic [2:0] S_RD0W1 = 3'd2;
    localparam logic [2:0] S_RD1   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;

    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

    logic [2:0]    state;
    logic          cmp_vld;
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] cmp_exp;
    logic          mismatch;

    // dout is registered by the RAM, so it lines up with the pipe stage captured on the read cycle
    assign mismatch = cmp_vld && (dout != cmp_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            we        <= 1'b0;
            addr      <= '0;
            din       <= '0;
            cmp_vld   <= 1'b0;
            cmp_addr  <= '0;
            cmp_exp   <= '0;
`ifdef RAM_MARCH_BIST_ERRCNT_EN
            err_cnt   <= '0;
`endif
        end else begin
            done    <= 1'b0;
            cmp_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_WR0;
                        busy      <= 1'b1;
                        we        <= 1'b1;
                        addr      <= '0;
                        din       <= PATTERN;
                        pass      <= 1'b0;
                        fail_addr <= '0;
`ifdef RAM_MARCH_BIST_ERRCNT_EN
                        err_cnt   <= '0;
`endif
                    end
                end
                S_WR0: begin
                    if (addr == ADDR_MAX) begin
                        state <= S_RD0W1;
                        we    <= 1'b0;
                        addr  <= '0;
                        din   <= ~PATTERN;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                S_RD0W1: begin
                    if (!we) begin
                        we       <= 1'b1;
                        cmp_vld  <= 1'b1;
                        cmp_addr <= addr;
                        cmp_exp  <= PATTERN;
                    end else if (addr == ADDR_MAX) begin
                        state <= S_RD1;
                        we    <= 1'b0;
                        din   <= '0;
                    end else begin
                        we   <= 1'b0;
                        addr <= addr + 1'b1;
                    end
                end
                S_RD1: begin
                    cmp_vld  <= 1'b1;
                    cmp_addr <= addr;
                    cmp_exp  <= ~PATTERN;
                    if (addr == '0) begin
                        state <= S_DRAIN;
                    end else begin
                        addr <= addr - 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    addr  <= '0;
                    din   <= '0;
`ifdef RAM_MARCH_BIST_ERRCNT_EN
                    pass  <= (err_cnt == '0) && !mismatch;
`else
                    pass  <= !mismatch;
`endif
                end
                S_FAIL: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

`ifdef RAM_MARCH_BIST_ERRCNT_EN
            if (mismatch) begin
                if (err_cnt != {(AW+1){1'b1}}) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (err_cnt == '0) begin
                    fail_addr <= cmp_addr;
                end
            end
`else
            // Abort overrides whatever the phase logic chose; the S_FAIL cycle carries the done pulse
            if (mismatch) begin
                state     <= S_FAIL;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b0;
                we        <= 1'b0;
                addr      <= '0;
                din       <= '0;
                cmp_vld   <= 1'b0;
                fail_addr <= cmp_addr;
            end
`endif
        end
    end

endmodule
